// File: rtl/ysyx_22050612_wbu_pkg.sv
// Shared definitions for the writeback unit.
//   - source-select encoding used by the arbiter's last_grant state
//   - default register-index / data / counter widths
//   - index of the hard-wired zero register
package ysyx_22050612_wbu_pkg;

    localparam int WBU_ADDR_WIDTH = 5;
    localparam int WBU_DATA_WIDTH = 64;
    localparam int WBU_CNT_WIDTH  = 64;

    // x0 reads as zero: never written, never pending, never busy
    localparam int WBU_X0 = 0;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wbu_src_e;

endpackage

// File: rtl/ysyx_22050612_wbu_scoreboard.sv
// Pending-load scoreboard for the writeback unit.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   set_en, set_idx     a load to set_idx was issued this cycle
//   clr_en, clr_idx     a load result to clr_idx was accepted this cycle
//   rf_wen, rf_waddr    staged register-file write (still not readable)
//   rs1, rs2            hazard query indices
//   rs1_busy, rs2_busy  query index not yet readable from the register file
//   sb_err              sticky: load issued to a register already pending
module ysyx_22050612_wbu_scoreboard
    import ysyx_22050612_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic                  rf_wen,
    input  logic [ADDR_WIDTH-1:0] rf_waddr,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  sb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(WBU_X0);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            set_v;
    logic            dup;

    assign set_v = set_en && (set_idx != X0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_v)  set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    // A register being cleared this cycle may be re-issued without error.
    assign dup = set_v && pending[set_idx] && !clr_mask[set_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            // set applied after clear so a same-cycle set wins
            pending <= (pending & ~clr_mask) | set_mask;
            if (dup) sb_err <= 1'b1;
        end
    end

    // The staged write lands in the register file one edge later, so a
    // register sitting in the output stage is still unreadable.
    assign rs1_busy = (rs1 != X0) && (pending[rs1] || (rf_wen && rf_waddr == rs1));
    assign rs2_busy = (rs2 != X0) && (pending[rs2] || (rf_wen && rf_waddr == rs2));

endmodule

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: round-robin arbitration between the execute path and the
// load/store unit, a single output register feeding the register-file write
// port (never stalls), x0 write suppression, retire counter and a
// pending-load scoreboard for RAW hazard queries.
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   exu_valid/ready/wen/rd/data         execute result handshake
//   lsu_valid/ready/rd/data             load result handshake
//   iss_set, iss_rd                     load issue (marks rd pending)
//   rs1, rs2 -> rs1_busy, rs2_busy      hazard queries
//   rf_wen, rf_waddr, rf_wdata          register-file write port
//   retire_cnt                          accepted writebacks (wraps)
//   sb_err                              sticky duplicate-pending error
module ysyx_22050612_wbu
    import ysyx_22050612_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
    parameter int DATA_WIDTH = WBU_DATA_WIDTH,
    parameter int CNT_WIDTH  = WBU_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic                  exu_wen,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_set,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic                  sb_err
);

    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(WBU_X0);

    wbu_src_e              last_grant;
    logic                  grant_exu;
    logic                  grant_lsu;
    logic                  acc;
    wbu_src_e              win_src;
    logic                  win_wen;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // Round-robin: on contention the source that did not win last time goes.
    assign grant_exu = exu_valid && (!lsu_valid || last_grant == SRC_LSU);
    assign grant_lsu = lsu_valid && (!exu_valid || last_grant == SRC_EXU);

    // When idle, ready still reflects who would win so it never depends on
    // the requester's own valid.
    assign exu_ready = exu_valid ? grant_exu : (!lsu_valid || last_grant == SRC_LSU);
    assign lsu_ready = lsu_valid ? grant_lsu : (!exu_valid || last_grant == SRC_EXU);

    assign acc = grant_exu || grant_lsu;

    always_comb begin
        win_src  = SRC_EXU;
        win_wen  = exu_wen;
        win_rd   = exu_rd;
        win_data = exu_data;
        if (grant_lsu) begin
            win_src  = SRC_LSU;
            win_wen  = 1'b1;
            win_rd   = lsu_rd;
            win_data = lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            retire_cnt <= '0;
            last_grant <= SRC_EXU;
        end else begin
            rf_wen <= 1'b0;
            if (acc) begin
                rf_wen     <= win_wen && (win_rd != X0);
                rf_waddr   <= win_rd;
                rf_wdata   <= win_data;
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
                last_grant <= win_src;
            end
        end
    end

    ysyx_22050612_wbu_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_set),
        .set_idx  (iss_rd),
        .clr_en   (grant_lsu),
        .clr_idx  (lsu_rd),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
module tb_ysyx_22050612_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, exu_wen, lsu_valid, iss_set;
    logic        exu_ready, lsu_ready, rs1_busy, rs2_busy, rf_wen, sb_err;
    logic [4:0]  exu_rd, lsu_rd, iss_rd, rs1, rs2, rf_waddr;
    logic [63:0] exu_data, lsu_data, rf_wdata, retire_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    ysyx_22050612_wbu dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_set(iss_set), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_cnt(retire_cnt), .sb_err(sb_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the head of the queue.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {59'd0, rf_waddr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {59'd0, rf_waddr}, {59'd0, e.addr});
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid = 0; lsu_valid = 0; iss_set = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; idle();
        exu_wen = 0; exu_rd = 0; exu_data = 0; lsu_rd = 0; lsu_data = 0;
        iss_rd = 0; rs1 = 0; rs2 = 0;
        #2;
        chk("rst_rf_wen", {63'd0, rf_wen}, 0);
        chk("rst_waddr", {59'd0, rf_waddr}, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_sb_err", {63'd0, sb_err}, 0);
        tick();
        rst_n = 1;

        // single EXU write
        exu_valid = 1; exu_wen = 1; exu_rd = 5; exu_data = 64'hDEAD;
        #1;
        chk("exu_ready_single", {63'd0, exu_ready}, 1);
        exp_q.push_back('{5'd5, 64'hDEAD});
        tick(); idle();
        chk("single_rf_wen", {63'd0, rf_wen}, 1);
        chk("retire_1", retire_cnt, 1);

        // write to x0: retired but suppressed
        exu_valid = 1; exu_wen = 1; exu_rd = 0; exu_data = 64'h1234;
        #1;
        chk("exu_ready_x0", {63'd0, exu_ready}, 1);
        tick(); idle();
        chk("x0_rf_wen", {63'd0, rf_wen}, 0);
        chk("x0_waddr", {59'd0, rf_waddr}, 0);
        chk("retire_2", retire_cnt, 2);

        // contention: LSU, EXU, LSU, EXU
        exu_valid = 1; exu_rd = 3; exu_data = 64'h33;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_lsu_ready", {63'd0, lsu_ready}, (i % 2 == 0) ? 1 : 0);
            chk("rr_exu_ready", {63'd0, exu_ready}, (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) exp_q.push_back('{5'd7, 64'h77});
            else            exp_q.push_back('{5'd3, 64'h33});
            tick();
        end
        idle();
        chk("retire_6", retire_cnt, 6);

        // scoreboard: issue load to x9, then write it back
        iss_set = 1; iss_rd = 9; rs1 = 9; rs2 = 0;
        #1;
        chk("busy_same_cycle", {63'd0, rs1_busy}, 0);
        tick(); idle();
        chk("busy_pending", {63'd0, rs1_busy}, 1);
        chk("rs2_x0_busy", {63'd0, rs2_busy}, 0);
        lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99;
        exp_q.push_back('{5'd9, 64'h99});
        #1;
        chk("lsu_ready_9", {63'd0, lsu_ready}, 1);
        tick(); idle();
        chk("busy_staged", {63'd0, rs1_busy}, 1);
        tick();
        chk("busy_done", {63'd0, rs1_busy}, 0);
        chk("retire_7", retire_cnt, 7);

        // set and clear of x9 in the same cycle: set wins, no error
        iss_set = 1; iss_rd = 9;
        tick();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 64'hAB;
        exp_q.push_back('{5'd9, 64'hAB});
        tick(); idle();
        chk("setclr_err", {63'd0, sb_err}, 0);
        tick();
        chk("setclr_pending", {63'd0, rs1_busy}, 1);
        iss_set = 1; iss_rd = 9;
        tick(); idle();
        chk("dup_err", {63'd0, sb_err}, 1);
        tick();
        chk("dup_err_sticky", {63'd0, sb_err}, 1);

        // asynchronous reset while a write is staged
        exu_valid = 1; exu_wen = 1; exu_rd = 12; exu_data = 64'hC0FFEE;
        exp_q.push_back('{5'd12, 64'hC0FFEE});
        tick();
        chk("pre_rst_retire", retire_cnt, 9);
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("arst_rf_wen", {63'd0, rf_wen}, 0);
        chk("arst_retire", retire_cnt, 0);
        chk("arst_sb_err", {63'd0, sb_err}, 0);
        chk("arst_busy", {63'd0, rs1_busy}, 0);
        tick();
        chk("rst_hold_rf_wen", {63'd0, rf_wen}, 0);
        chk("rst_hold_retire", retire_cnt, 0);
        idle();
        rst_n = 1;
        tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
